regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 34 +++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared definitions for the register-file write-back controller.
//   RF_WIDTH   : default register data width
//   RF_REGADDR : default register address width
//   RF_NREGS   : default number of registers cleared by the init sweep
//   STALL_W    : width of the saturating stall counter
//   wb_state_e : controller state (init sweep, then normal run)
//   req_id_e   : write-back requester identifiers
//   sat_inc    : saturating increment for the stall counter
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   localparam int unsigned RF_WIDTH   = 32;
   localparam int unsigned RF_REGADDR = 5;
   localparam int unsigned RF_NREGS   = 32;
   localparam int unsigned STALL_W    = 16;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } wb_state_e;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_e;

   // Holds at all-ones instead of wrapping back to zero.
   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter between the ALU and load write-back requesters.
// The grant is combinational; only the most-recently-accepted requester is
// stored.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : arbitration enabled (controller in run state)
//   i_alu_valid    : ALU request
//   i_mem_valid    : load request
//   o_alu_ready    : ALU granted this cycle
//   o_mem_ready    : load granted this cycle
//   o_grant        : requester currently selected
// -----------------------------------------------------------------------------
module rr_arb2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_en,
   input  logic    i_alu_valid,
   input  logic    i_mem_valid,
   output logic    o_alu_ready,
   output logic    o_mem_ready,
   output req_id_e o_grant
);

   req_id_e r_last_grant;
   req_id_e w_grant;
   logic    w_hs;

   // A lone requester always wins. With both (or neither) requesting, the one
   // not accepted most recently is favoured, so contention alternates.
   always_comb begin
      w_grant = REQ_ALU;
      case ({i_alu_valid, i_mem_valid})
         2'b10:   w_grant = REQ_ALU;
         2'b01:   w_grant = REQ_MEM;
         default: w_grant = (r_last_grant == REQ_MEM) ? REQ_ALU : REQ_MEM;
      endcase
   end

   assign o_alu_ready = i_en && (w_grant == REQ_ALU);
   assign o_mem_ready = i_en && (w_grant == REQ_MEM);
   assign o_grant     = w_grant;

   // Ready without valid is not a handshake and must not move the pointer.
   assign w_hs = (i_alu_valid && o_alu_ready) || (i_mem_valid && o_mem_ready);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_grant <= REQ_MEM;
      end else if (w_hs) begin
         r_last_grant <= w_grant;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Owner of the register file's single write port. After reset it sweeps every
// register to zero (the file itself has no reset), then arbitrates ALU and
// load write-backs round-robin into a registered write.
//   i_clk, i_rst_n                      : clock, asynchronous active-low reset
//   i_alu_valid/i_alu_rd/i_alu_data     : ALU write-back request
//   o_alu_ready                         : ALU request accepted this cycle
//   i_mem_valid/i_mem_rd/i_mem_data     : load write-back request
//   o_mem_ready                         : load request accepted this cycle
//   o_rf_RegWrite/o_rf_RW/o_rf_busW     : register file write port
//   o_init_done                         : clear sweep finished
//   o_stall_cnt                         : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = RF_WIDTH,
   parameter int unsigned AW    = RF_REGADDR,
   parameter int unsigned NREGS = RF_NREGS
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_alu_valid,
   input  logic [AW-1:0]      i_alu_rd,
   input  logic [WIDTH-1:0]   i_alu_data,
   output logic               o_alu_ready,
   input  logic               i_mem_valid,
   input  logic [AW-1:0]      i_mem_rd,
   input  logic [WIDTH-1:0]   i_mem_data,
   output logic               o_mem_ready,
   output logic               o_rf_RegWrite,
   output logic [AW-1:0]      o_rf_RW,
   output logic [WIDTH-1:0]   o_rf_busW,
   output logic               o_init_done,
   output logic [STALL_W-1:0] o_stall_cnt
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   wb_state_e          r_state;
   logic [AW-1:0]      r_init_cnt;
   logic               r_regwrite;
   logic [AW-1:0]      r_rw;
   logic [WIDTH-1:0]   r_busw;
   logic               r_init_done;
   logic [STALL_W-1:0] r_stall_cnt;

   logic               w_run;
   logic               w_alu_ready;
   logic               w_mem_ready;
   req_id_e            w_grant;
   logic               w_hs;
   logic               w_stall;
   logic [AW-1:0]      w_sel_rd;
   logic [WIDTH-1:0]   w_sel_data;

   assign w_run = (r_state == ST_RUN);

   rr_arb2 u_arb (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (w_run),
      .i_alu_valid (i_alu_valid),
      .i_mem_valid (i_mem_valid),
      .o_alu_ready (w_alu_ready),
      .o_mem_ready (w_mem_ready),
      .o_grant     (w_grant)
   );

   assign w_hs       = (i_alu_valid && w_alu_ready) || (i_mem_valid && w_mem_ready);
   assign w_sel_rd   = (w_grant == REQ_ALU) ? i_alu_rd   : i_mem_rd;
   assign w_sel_data = (w_grant == REQ_ALU) ? i_alu_data : i_mem_data;

   // Counts INIT cycles too: readies are low there, so any valid requester stalls.
   assign w_stall = (i_alu_valid && !w_alu_ready) || (i_mem_valid && !w_mem_ready);

   // Controller FSM with registered write-port outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         r_regwrite  <= 1'b0;
         r_rw        <= '0;
         r_busw      <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_regwrite <= 1'b1;
               r_rw       <= r_init_cnt;
               r_busw     <= '0;
               r_init_cnt <= r_init_cnt + 1'b1;
               // Switch on the same edge that presents the last clear, so the
               // first request can be accepted while that write is on the port.
               if (r_init_cnt == LAST_IDX) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_hs) begin
                  // x0 is hardwired zero: accept the request but suppress the write.
                  r_regwrite <= (w_sel_rd != '0);
                  r_rw       <= w_sel_rd;
                  r_busw     <= w_sel_data;
               end else begin
                  r_regwrite <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   assign o_alu_ready   = w_alu_ready;
   assign o_mem_ready   = w_mem_ready;
   assign o_rf_RegWrite = r_regwrite;
   assign o_rf_RW       = r_rw;
   assign o_rf_busW     = r_busw;
   assign o_init_done   = r_init_done;
   assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. A behavioural model tracks the
// expected write port, readies, stall count and register-file contents.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int W = 32;
   localparam int A = 5;
   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           alu_valid = 1'b0;
   logic [A-1:0]   alu_rd = '0;
   logic [W-1:0]   alu_data = '0;
   logic           alu_ready;
   logic           mem_valid = 1'b0;
   logic [A-1:0]   mem_rd = '0;
   logic [W-1:0]   mem_data = '0;
   logic           mem_ready;
   logic           rf_we;
   logic [A-1:0]   rf_rw;
   logic [W-1:0]   rf_busw;
   logic           init_done;
   logic [15:0]    stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .WIDTH (W),
      .AW    (A),
      .NREGS (N)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_alu_valid   (alu_valid),
      .i_alu_rd      (alu_rd),
      .i_alu_data    (alu_data),
      .o_alu_ready   (alu_ready),
      .i_mem_valid   (mem_valid),
      .i_mem_rd      (mem_rd),
      .i_mem_data    (mem_data),
      .o_mem_ready   (mem_ready),
      .o_rf_RegWrite (rf_we),
      .o_rf_RW       (rf_rw),
      .o_rf_busW     (rf_busw),
      .o_init_done   (init_done),
      .o_stall_cnt   (stall_cnt)
   );

   // The register file being written (has no reset of its own).
   logic [W-1:0] rf [N];
   always @(posedge clk) if (rf_we) rf[rf_rw] <= rf_busw;

   // ---------------- behavioural model ----------------
   logic [W-1:0] exp_rf [N];
   bit           m_run;
   int           m_cnt;
   bit           m_last_mem;
   bit           m_we;
   logic [A-1:0] m_rw;
   logic [W-1:0] m_busw;
   bit           m_done;
   int           m_stall;
   bit           e_ra, e_rm;

   function automatic void model_reset();
      m_run = 0; m_cnt = 0; m_last_mem = 1; m_we = 0;
      m_rw = '0; m_busw = '0; m_done = 0; m_stall = 0;
   endfunction

   // Who should be accepted right now, from the current requests.
   function automatic void model_ready();
      e_ra = 0; e_rm = 0;
      if (m_run) begin
         if (alu_valid && !mem_valid) e_ra = 1;
         else if (mem_valid && !alu_valid) e_rm = 1;
         else if (alu_valid && mem_valid) begin
            if (m_last_mem) e_ra = 1; else e_rm = 1;
         end
      end
   endfunction

   // Effect of one rising edge on the model.
   function automatic void model_edge();
      model_ready();
      if (m_we) exp_rf[m_rw] = m_busw;
      if (((alu_valid && !e_ra) || (mem_valid && !e_rm)) && m_stall < 65535) m_stall++;
      if (!m_run) begin
         m_we = 1; m_rw = A'(m_cnt); m_busw = '0;
         if (m_cnt == N - 1) begin m_run = 1; m_done = 1; end
         m_cnt++;
      end else if (alu_valid && e_ra) begin
         m_we = (alu_rd != 0); m_rw = alu_rd; m_busw = alu_data; m_last_mem = 0;
      end else if (mem_valid && e_rm) begin
         m_we = (mem_rd != 0); m_rw = mem_rd; m_busw = mem_data; m_last_mem = 1;
      end else begin
         m_we = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      model_reset();
      #13;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      alu_valid = 1; mem_valid = 1;
      hold_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", rf_we); end
      n_cmp++; if (rf_rw !== '0) begin n_bad++; $display("FAIL reset_rw got=%0d want=0", rf_rw); end
      n_cmp++; if (rf_busw !== '0) begin n_bad++; $display("FAIL reset_busw got=%h want=0", rf_busw); end
      n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", init_done); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
      n_cmp++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready got=%b%b want=00", alu_ready, mem_ready);
      end
      alu_valid = 0; mem_valid = 0;
   endtask

   task automatic test_init_sweep();
      release_reset();
      for (int i = 0; i < N; i++) begin
         tick();
         n_cmp++;
         if (rf_we !== 1'b1 || rf_we !== m_we || rf_rw !== m_rw || rf_busw !== m_busw ||
             init_done !== m_done || init_done !== (i == N - 1)) begin
            n_bad++;
            $display("FAIL init_sweep[%0d] got we=%b rw=%0d busw=%h done=%b want we=%b rw=%0d busw=%h done=%b",
                     i, rf_we, rf_rw, rf_busw, init_done, m_we, m_rw, m_busw, m_done);
         end
      end
      tick();
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL init_after_we got=%b want=0", rf_we); end
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (rf[i] !== exp_rf[i] || rf[i] !== '0) begin
            n_bad++; $display("FAIL init_clear r%0d got=%h want=%h", i, rf[i], exp_rf[i]);
         end
      end
   endtask

   task automatic test_contention();
      int prev;
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
      mem_valid = 1; mem_rd = 5'd2; mem_data = 32'h22;
      for (int k = 0; k < 8; k++) begin
         #1;
         model_ready();
         n_cmp++;
         if (alu_ready !== e_ra || mem_ready !== e_rm || alu_ready !== (k % 2 == 0)) begin
            n_bad++;
            $display("FAIL contend_grant[%0d] got alu=%b mem=%b want alu=%b mem=%b",
                     k, alu_ready, mem_ready, e_ra, e_rm);
         end
         prev = m_stall;
         tick();
         n_cmp++;
         if (stall_cnt !== 16'(m_stall) || m_stall != prev + 1) begin
            n_bad++; $display("FAIL contend_stall[%0d] got=%0d want=%0d", k, stall_cnt, prev + 1);
         end
         n_cmp++;
         if (rf_we !== 1'b1 || rf_rw !== ((k % 2 == 0) ? 5'd1 : 5'd2) || rf_busw !== m_busw) begin
            n_bad++;
            $display("FAIL contend_write[%0d] got we=%b rw=%0d busw=%h want we=1 rw=%0d busw=%h",
                     k, rf_we, rf_rw, rf_busw, m_rw, m_busw);
         end
      end
      alu_valid = 0; mem_valid = 0;
      tick();
   endtask

   task automatic test_single();
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      n_cmp++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
         n_bad++; $display("FAIL single_ready got alu=%b mem=%b want alu=1 mem=0", alu_ready, mem_ready);
      end
      tick();
      alu_valid = 0;
      n_cmp++; if (rf_we !== 1'b1 || rf_rw !== 5'd5 || rf_busw !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL single_write got we=%b rw=%0d busw=%h want we=1 rw=5 busw=deadbeef",
                           rf_we, rf_rw, rf_busw);
      end
      tick();
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL single_idle_we got=%b want=0", rf_we); end
      n_cmp++; if (rf[5] !== 32'hDEADBEEF || rf[5] !== exp_rf[5]) begin
         n_bad++; $display("FAIL single_rf5 got=%h want=deadbeef", rf[5]);
      end
   endtask

   task automatic test_x0();
      mem_valid = 1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
      #1;
      n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready got=%b want=1", mem_ready); end
      tick();
      mem_valid = 0;
      n_cmp++; if (rf_we !== 1'b0 || rf_we !== m_we) begin
         n_bad++; $display("FAIL x0_we got=%b want=0", rf_we);
      end
      tick();
      n_cmp++; if (rf[0] !== 32'h0 || rf[0] !== exp_rf[0]) begin
         n_bad++; $display("FAIL x0_rf0 got=%h want=0", rf[0]);
      end
   endtask

   task automatic test_random();
      int wa = 0, wm = 0;
      for (int c = 0; c < 300; c++) begin
         if (!alu_valid && $urandom_range(0, 2) != 0) begin
            alu_valid = 1; alu_rd = A'($urandom_range(0, N - 1)); alu_data = $urandom;
         end
         if (!mem_valid && $urandom_range(0, 2) != 0) begin
            mem_valid = 1; mem_rd = A'($urandom_range(0, N - 1)); mem_data = $urandom;
         end
         #1;
         model_ready();
         n_cmp++;
         if ((alu_valid && alu_ready !== e_ra) || (mem_valid && mem_ready !== e_rm) ||
             (alu_ready && mem_ready)) begin
            n_bad++;
            $display("FAIL rand_ready[%0d] got alu=%b mem=%b want alu=%b mem=%b (valid %b%b)",
                     c, alu_ready, mem_ready, e_ra, e_rm, alu_valid, mem_valid);
         end
         tick();
         n_cmp++;
         if (rf_we !== m_we || (m_we && (rf_rw !== m_rw || rf_busw !== m_busw)) ||
             stall_cnt !== 16'(m_stall)) begin
            n_bad++;
            $display("FAIL rand_out[%0d] got we=%b rw=%0d busw=%h stall=%0d want we=%b rw=%0d busw=%h stall=%0d",
                     c, rf_we, rf_rw, rf_busw, stall_cnt, m_we, m_rw, m_busw, m_stall);
         end
         wa = (alu_valid && !e_ra) ? wa + 1 : 0;
         wm = (mem_valid && !e_rm) ? wm + 1 : 0;
         n_cmp++;
         if (wa > 1 || wm > 1) begin
            n_bad++; $display("FAIL rand_wait[%0d] got alu=%0d mem=%0d want<=1", c, wa, wm);
         end
         if (alu_valid && e_ra) alu_valid = 0;
         if (mem_valid && e_rm) mem_valid = 0;
      end
      alu_valid = 0; mem_valid = 0;
      tick(); tick();
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (rf[i] !== exp_rf[i]) begin
            n_bad++; $display("FAIL rand_rf r%0d got=%h want=%h", i, rf[i], exp_rf[i]);
         end
      end
   endtask

   task automatic test_valid_during_init();
      bit found = 0;
      hold_reset();
      release_reset();
      tick();
      alu_valid = 1; alu_rd = 5'd7; alu_data = $urandom;
      for (int c = 0; c < 40 && !found; c++) begin
         #1;
         model_ready();
         n_cmp++;
         if (alu_ready !== e_ra) begin
            n_bad++; $display("FAIL init_valid_ready[%0d] got=%b want=%b", c, alu_ready, e_ra);
         end
         if (alu_ready === 1'b1) found = 1;
         else tick();
      end
      n_cmp++;
      if (!found) begin
         n_bad++; $display("FAIL init_valid_timeout got=no_ready want=ready_within_40");
      end else if (stall_cnt !== 16'd31 || stall_cnt !== 16'(m_stall) || rf_rw !== 5'd31 ||
                   init_done !== 1'b1) begin
         n_bad++;
         $display("FAIL init_valid_accept got stall=%0d rw=%0d done=%b want stall=31 rw=31 done=1",
                  stall_cnt, rf_rw, init_done);
      end
      tick();
      alu_valid = 0;
      n_cmp++; if (rf_we !== 1'b1 || rf_rw !== 5'd7 || rf_busw !== m_busw) begin
         n_bad++; $display("FAIL init_valid_write got we=%b rw=%0d busw=%h want we=1 rw=7 busw=%h",
                           rf_we, rf_rw, rf_busw, m_busw);
      end
   endtask

   task automatic test_mid_reset();
      alu_valid = 1; alu_rd = 5'd9; alu_data = $urandom;
      #1;
      tick();
      alu_valid = 0;
      n_cmp++; if (rf_we !== 1'b1 || rf_rw !== 5'd9) begin
         n_bad++; $display("FAIL midrst_pre got we=%b rw=%0d want we=1 rw=9", rf_we, rf_rw);
      end
      mem_valid = 1;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we got=%b want=0", rf_we); end
      n_cmp++; if (rf_rw !== '0 || rf_busw !== '0 || init_done !== 1'b0 || stall_cnt !== 16'd0) begin
         n_bad++; $display("FAIL midrst_regs got rw=%0d busw=%h done=%b stall=%0d want all 0",
                           rf_rw, rf_busw, init_done, stall_cnt);
      end
      n_cmp++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         n_bad++; $display("FAIL midrst_ready got=%b%b want=00", alu_ready, mem_ready);
      end
      mem_valid = 0;
      model_reset();
      release_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (rf_we !== 1'b1 || rf_rw !== m_rw || rf_rw !== A'(i) || rf_busw !== '0) begin
            n_bad++; $display("FAIL midrst_sweep[%0d] got we=%b rw=%0d busw=%h want we=1 rw=%0d busw=0",
                              i, rf_we, rf_rw, rf_busw, i);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init_sweep();
      test_contention();
      test_single();
      test_x0();
      test_random();
      test_valid_during_init();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
